// File: rtl/patgen_pkg.sv
// Shared definitions for the patgen step sequencer: patgen register map,
// step-entry field layout, FSM encoding and byte-order helpers.
package patgen_pkg;

  localparam logic [3:0] PG_ADDR_NUMPULSES = 4'd7;
  localparam logic [3:0] PG_ADDR_PERIODE   = 4'd8;
  localparam logic [3:0] PG_ADDR_RUNLEN_HI = 4'd10;
  localparam logic [3:0] PG_ADDR_RUNLEN_LO = 4'd11;
  localparam logic [3:0] PG_ADDR_IDELAY_HI = 4'd12;
  localparam logic [3:0] PG_ADDR_IDELAY_LO = 4'd13;
  localparam logic [3:0] PG_ADDR_CLKFAC_HI = 4'd14;
  localparam logic [3:0] PG_ADDR_CLKFAC_LO = 4'd15;

  localparam int F_NUMPULSES = 0;
  localparam int F_PERIODE   = 8;
  localparam int F_RUNLEN    = 16;
  localparam int F_IDELAY    = 32;
  localparam int F_CLKFAC    = 48;

  localparam int PROG_BYTES = 8;
  localparam int RUN_BLANK  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PROG,
    ST_ARM,
    ST_RUN,
    ST_NEXT
  } state_t;

  function automatic logic [3:0] prog_addr(input logic [2:0] k);
    case (k)
      3'd0:    prog_addr = PG_ADDR_NUMPULSES;
      3'd1:    prog_addr = PG_ADDR_PERIODE;
      3'd2:    prog_addr = PG_ADDR_RUNLEN_HI;
      3'd3:    prog_addr = PG_ADDR_RUNLEN_LO;
      3'd4:    prog_addr = PG_ADDR_IDELAY_HI;
      3'd5:    prog_addr = PG_ADDR_IDELAY_LO;
      3'd6:    prog_addr = PG_ADDR_CLKFAC_HI;
      default: prog_addr = PG_ADDR_CLKFAC_LO;
    endcase
  endfunction

  function automatic logic [7:0] prog_byte(input logic [63:0] e, input logic [2:0] k);
    case (k)
      3'd0:    prog_byte = e[F_NUMPULSES +: 8];
      3'd1:    prog_byte = e[F_PERIODE +: 8];
      3'd2:    prog_byte = e[F_RUNLEN + 8 +: 8];
      3'd3:    prog_byte = e[F_RUNLEN +: 8];
      3'd4:    prog_byte = e[F_IDELAY + 8 +: 8];
      3'd5:    prog_byte = e[F_IDELAY +: 8];
      3'd6:    prog_byte = e[F_CLKFAC + 8 +: 8];
      default: prog_byte = e[F_CLKFAC +: 8];
    endcase
  endfunction

  function automatic int clamp_idx(input int idx, input int depth);
    return (idx > depth - 1) ? depth - 1 : idx;
  endfunction

endpackage

// File: rtl/patgen_step_ram.sv
// Step table: DEPTH x W, one write port, one read port with registered output.
// Read data only changes on a read enable, so it holds across programming.
module patgen_step_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/patgen_seq_ctrl.sv
// Step sequencer for sync_async_patgen: fetches table entries, programs the
// patgen over its byte bus, releases it and waits for done, one pass or looping.
//
// state | meaning
// IDLE  | waiting for start, patgen held in reset
// FETCH | table read issued at step_idx
// PROG  | 8 register writes, one byte per cycle
// ARM   | patgen captures the last write, still in reset
// RUN   | patgen released; done ignored for the first 2 cycles
// NEXT  | advance, wrap or finish
module patgen_seq_ctrl
  import patgen_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [63:0]   tbl_wdata,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] last_idx,
  input  logic          loop,
  input  logic          ext_suspend,
  output logic          pg_write,
  output logic [3:0]    pg_addr,
  output logic [7:0]    pg_din,
  output logic          pg_rst,
  output logic          pg_suspend,
  input  logic          pg_done,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          step_start,
  output logic          seq_done
);

  state_t        state, state_nx;
  logic [AW-1:0] last_q;
  logic          loop_q;
  logic [2:0]    prog_cnt;
  logic [1:0]    run_cnt;
  logic [63:0]   rd_data;
  logic          more_steps;

  patgen_step_ram #(.DEPTH(DEPTH), .AW(AW), .W(64)) u_ram (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (tbl_addr),
    .wdata (tbl_wdata),
    .re    (state == ST_FETCH),
    .raddr (step_idx),
    .rdata (rd_data)
  );

  assign more_steps = (step_idx < last_q) || loop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      step_idx <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
      seq_done <= 1'b0;
      prog_cnt <= 3'd0;
      run_cnt  <= 2'd0;
    end else begin
      state    <= state_nx;
      prog_cnt <= (state == ST_PROG) ? prog_cnt + 3'd1 : 3'd0;
      if (state != ST_RUN) run_cnt <= 2'd0;
      else if (run_cnt != 2'(RUN_BLANK)) run_cnt <= run_cnt + 2'd1;
      if (!abort) begin
        if (state == ST_IDLE && start) begin
          last_q   <= AW'(clamp_idx(int'(last_idx), DEPTH));
          loop_q   <= loop;
          step_idx <= '0;
          seq_done <= 1'b0;
        end
        if (state == ST_NEXT) begin
          if (step_idx < last_q) step_idx <= step_idx + AW'(1);
          else if (loop_q) step_idx <= '0;
          else seq_done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_FETCH;
      ST_FETCH: state_nx = ST_PROG;
      ST_PROG:  if (prog_cnt == 3'(PROG_BYTES - 1)) state_nx = ST_ARM;
      ST_ARM:   state_nx = ST_RUN;
      ST_RUN:   if (run_cnt == 2'(RUN_BLANK) && pg_done) state_nx = ST_NEXT;
      ST_NEXT:  state_nx = more_steps ? ST_FETCH : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_comb begin
    pg_write   = 1'b0;
    pg_addr    = 4'd0;
    pg_din     = 8'd0;
    pg_rst     = 1'b1;
    pg_suspend = 1'b0;
    step_start = 1'b0;
    case (state)
      ST_PROG: begin
        pg_write = 1'b1;
        pg_addr  = prog_addr(prog_cnt);
        pg_din   = prog_byte(rd_data, prog_cnt);
      end
      ST_RUN: begin
        pg_rst     = 1'b0;
        pg_suspend = ext_suspend;
        step_start = (run_cnt == 2'd0);
      end
      default: ;
    endcase
    // abort takes the patgen back into reset in the same cycle
    if (abort) begin
      pg_write = 1'b0;
      pg_rst   = 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_patgen_seq_ctrl.sv
// Self-checking bench for patgen_seq_ctrl with a behavioural patgen model and
// a reference of expected register writes, step order and RUN timing.
module tb_patgen_seq_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SH[8] = '{0, 8, 24, 16, 40, 32, 56, 48};
  localparam int AD[8] = '{7, 8, 10, 11, 12, 13, 14, 15};

  logic          clk = 1'b0;
  logic          rst;
  logic          tbl_we;
  logic [AW-1:0] tbl_addr;
  logic [63:0]   tbl_wdata;
  logic          start, abort, loop, ext_suspend;
  logic [AW-1:0] last_idx;
  logic          pg_write, pg_rst, pg_suspend, pg_done;
  logic [3:0]    pg_addr;
  logic [7:0]    pg_din;
  logic          busy, step_start, seq_done;
  logic [AW-1:0] step_idx;

  patgen_seq_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .start(start), .abort(abort), .last_idx(last_idx), .loop(loop),
    .ext_suspend(ext_suspend), .pg_write(pg_write), .pg_addr(pg_addr), .pg_din(pg_din),
    .pg_rst(pg_rst), .pg_suspend(pg_suspend), .pg_done(pg_done), .busy(busy),
    .step_idx(step_idx), .step_start(step_start), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // patgen model: registers, run counter paused by suspend, done stale for 2 cycles
  logic [7:0]  pg_regs [16];
  logic [15:0] pg_runlen;
  int          elapsed;
  logic        armed;
  assign pg_runlen = {pg_regs[10], pg_regs[11]};

  always @(posedge clk) begin
    if (rst) begin
      pg_done <= 1'b0;
      elapsed <= 0;
      armed   <= 1'b0;
    end else begin
      if (pg_write) pg_regs[pg_addr] <= pg_din;
      if (pg_rst) begin
        elapsed <= 0;
        armed   <= 1'b0;
      end else begin
        armed <= 1'b1;
        if (!pg_suspend) elapsed <= elapsed + 1;
        if (armed) pg_done <= (pg_runlen != 16'd0) && (elapsed >= int'(pg_runlen));
      end
    end
  end

  // monitor, samples 2 ns after the falling edge
  logic [15:0] wq[$];
  int          wcyc[$];
  int          ssq[$];
  int          run_start_q[$], run_end_q[$];
  int          susp_cnt, susp_bad, cur_run_start;
  logic        prev_rst = 1'b1;

  always @(negedge clk) begin
    #2;
    if (pg_write) begin
      wq.push_back({step_idx, pg_addr, pg_din});
      wcyc.push_back(cyc);
    end
    if (step_start) ssq.push_back(int'(step_idx));
    if (!pg_rst && prev_rst) cur_run_start = cyc;
    if (pg_rst && !prev_rst) begin
      run_start_q.push_back(cur_run_start);
      run_end_q.push_back(cyc);
    end
    if (pg_suspend) susp_cnt++;
    if (pg_suspend && pg_rst) susp_bad++;
    prev_rst = pg_rst;
  end

  int          n_checks = 0, n_pass = 0;
  logic [63:0] tm [DEPTH];
  logic [15:0] exp_wq[$];
  int          start_cyc;

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic clear_mon();
    wq.delete(); wcyc.delete(); ssq.delete();
    run_start_q.delete(); run_end_q.delete();
    susp_cnt = 0; susp_bad = 0;
    exp_wq.delete();
  endtask

  function automatic logic [63:0] mk(int clkfac, int idelay, int runlen, int periode, int numpulses);
    return {16'(clkfac), 16'(idelay), 16'(runlen), 8'(periode), 8'(numpulses)};
  endfunction

  function automatic logic [63:0] rand_entry(int rl_lo, int rl_hi);
    logic [63:0] e;
    e = {$urandom, $urandom};
    e[31:16] = 16'($urandom_range(rl_hi, rl_lo));
    return e;
  endfunction

  function automatic void add_step(int idx);
    for (int k = 0; k < 8; k++)
      exp_wq.push_back({4'(idx), 4'(AD[k]), 8'((tm[idx] >> SH[k]) & 64'hFF)});
  endfunction

  function automatic int exp_run(int idx, int susp);
    return int'(tm[idx][31:16]) + 2 + susp;
  endfunction

  task automatic write_entry(input int idx, input logic [63:0] e);
    tbl_we = 1'b1; tbl_addr = AW'(idx); tbl_wdata = e;
    tm[idx] = e;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic do_start(input int last, input bit lp);
    last_idx = AW'(last); loop = lp; start = 1'b1; start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    tick();
    n_checks++; if (pg_rst !== 1'b1) $display("FAIL reset_pg_rst: got %b want 1", pg_rst); else n_pass++;
    n_checks++; if ({pg_write, pg_addr, pg_din, pg_suspend} !== 14'd0)
      $display("FAIL reset_bus: got %b/%h/%h/%b want 0", pg_write, pg_addr, pg_din, pg_suspend); else n_pass++;
    n_checks++; if ({busy, step_idx, step_start, seq_done} !== 7'd0)
      $display("FAIL reset_status: got %b/%0d/%b/%b want 0", busy, step_idx, step_start, seq_done); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    write_entry(0, mk(0, 4, 2, 1, 1));
    clear_mon();
    add_step(0);
    do_start(0, 0);
    wait_idle(500, ok);
    n_checks++; if (!ok) $display("FAIL single_timeout: busy=%b want 0", busy); else n_pass++;
    n_checks++; if (wq.size() != 8) $display("FAIL single_nwrites: got %0d want 8", wq.size()); else n_pass++;
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      n_checks++;
      if (wq[i] !== exp_wq[i]) $display("FAIL single_write%0d: got %h want %h", i, wq[i], exp_wq[i]);
      else n_pass++;
    end
    n_checks++; if (wcyc.size() == 0 || wcyc[0] - start_cyc != 2)
      $display("FAIL single_latency: got %0d want 2", wcyc.size() ? wcyc[0] - start_cyc : -1); else n_pass++;
    n_checks++; if (ssq.size() != 1) $display("FAIL single_step_starts: got %0d want 1", ssq.size()); else n_pass++;
    n_checks++; if (run_end_q.size() != 1 || run_end_q[0] - run_start_q[0] != 4)
      $display("FAIL single_runlen: got %0d want 4", run_end_q.size() ? run_end_q[0] - run_start_q[0] : -1); else n_pass++;
    n_checks++; if (seq_done !== 1'b1 || busy !== 1'b0 || pg_rst !== 1'b1)
      $display("FAIL single_end: got done=%b busy=%b pg_rst=%b want 1/0/1", seq_done, busy, pg_rst); else n_pass++;
  endtask

  task automatic test_multi();
    bit ok;
    int last;
    for (int it = 0; it < 3; it++) begin
      last = (it == 0) ? 2 : int'($urandom_range(4, 1));
      for (int k = 0; k <= last; k++) write_entry(k, rand_entry(1, 20));
      clear_mon();
      for (int k = 0; k <= last; k++) add_step(k);
      do_start(last, 0);
      wait_idle(3000, ok);
      n_checks++; if (!ok) $display("FAIL multi_timeout: busy=%b want 0", busy); else n_pass++;
      n_checks++; if (wq.size() != exp_wq.size())
        $display("FAIL multi_nwrites: got %0d want %0d", wq.size(), exp_wq.size()); else n_pass++;
      for (int i = 0; i < exp_wq.size() && i < wq.size(); i++) begin
        n_checks++;
        if (wq[i] !== exp_wq[i]) $display("FAIL multi_write%0d: got %h want %h", i, wq[i], exp_wq[i]);
        else n_pass++;
      end
      n_checks++; if (ssq.size() != last + 1)
        $display("FAIL multi_step_starts: got %0d want %0d", ssq.size(), last + 1); else n_pass++;
      for (int i = 0; i < ssq.size() && i <= last; i++) begin
        n_checks++;
        if (ssq[i] != i) $display("FAIL multi_step_idx%0d: got %0d want %0d", i, ssq[i], i); else n_pass++;
      end
      for (int i = 0; i < run_end_q.size() && i <= last; i++) begin
        n_checks++;
        if (run_end_q[i] - run_start_q[i] != exp_run(i, 0))
          $display("FAIL multi_run%0d: got %0d want %0d", i, run_end_q[i] - run_start_q[i], exp_run(i, 0));
        else n_pass++;
        if (i > 0) begin
          n_checks++;
          if (run_start_q[i] - run_end_q[i-1] != 11)
            $display("FAIL multi_gap%0d: got %0d want 11", i, run_start_q[i] - run_end_q[i-1]);
          else n_pass++;
        end
      end
      n_checks++; if (seq_done !== 1'b1) $display("FAIL multi_seq_done: got %b want 1", seq_done); else n_pass++;
    end
  endtask

  task automatic test_loop_abort();
    int n;
    int exp_idx[5] = '{0, 1, 0, 1, 0};
    write_entry(0, rand_entry(1, 15));
    write_entry(1, rand_entry(1, 15));
    clear_mon();
    add_step(0);
    do_start(1, 1);
    n = 0;
    while (wq.size() < 3 && n < 100) begin tick(); n++; end
    // rewrite entry 0 while it is being programmed: only its next fetch sees it
    write_entry(0, rand_entry(1, 15));
    add_step(1); add_step(0); add_step(1); add_step(0);
    n = 0;
    while (ssq.size() < 5 && n < 2000) begin tick(); n++; end
    n_checks++; if (ssq.size() < 5) $display("FAIL loop_timeout: got %0d steps want 5", ssq.size()); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || pg_rst !== 1'b1 || pg_write !== 1'b0)
      $display("FAIL abort_idle: got busy=%b pg_rst=%b pg_write=%b want 0/1/0", busy, pg_rst, pg_write); else n_pass++;
    n_checks++; if (seq_done !== 1'b0) $display("FAIL abort_seq_done: got %b want 0", seq_done); else n_pass++;
    for (int i = 0; i < 5 && i < ssq.size(); i++) begin
      n_checks++;
      if (ssq[i] != exp_idx[i]) $display("FAIL loop_step_idx%0d: got %0d want %0d", i, ssq[i], exp_idx[i]);
      else n_pass++;
    end
    n_checks++; if (wq.size() != 40) $display("FAIL loop_nwrites: got %0d want 40", wq.size()); else n_pass++;
    for (int i = 0; i < 40 && i < wq.size(); i++) begin
      n_checks++;
      if (wq[i] !== exp_wq[i]) $display("FAIL loop_write%0d: got %h want %h", i, wq[i], exp_wq[i]);
      else n_pass++;
    end
    abort = 1'b1; start = 1'b1; last_idx = '0; loop = 1'b0;
    tick();
    abort = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_with_start: got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_runlen0();
    int n = 0;
    write_entry(0, rand_entry(0, 0));
    clear_mon();
    do_start(0, 0);
    while (ssq.size() < 1 && n < 100) begin tick(); n++; end
    repeat (10000) tick();
    n_checks++; if (busy !== 1'b1 || pg_rst !== 1'b0 || run_end_q.size() != 0)
      $display("FAIL runlen0_hold: got busy=%b pg_rst=%b ends=%0d want 1/0/0", busy, pg_rst, run_end_q.size()); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || pg_rst !== 1'b1 || seq_done !== 1'b0)
      $display("FAIL runlen0_abort: got busy=%b pg_rst=%b done=%b want 0/1/0", busy, pg_rst, seq_done); else n_pass++;
  endtask

  task automatic test_suspend();
    bit ok;
    int n = 0;
    write_entry(0, rand_entry(30, 60));
    clear_mon();
    ext_suspend = 1'b1;
    do_start(0, 0);
    while (wq.size() < 8 && n < 100) begin tick(); n++; end
    ext_suspend = 1'b0;
    n_checks++; if (susp_cnt != 0) $display("FAIL suspend_in_prog: got %0d cycles want 0", susp_cnt); else n_pass++;
    n = 0;
    while (ssq.size() < 1 && n < 100) begin tick(); n++; end
    repeat (3) tick();
    ext_suspend = 1'b1;
    repeat (50) tick();
    ext_suspend = 1'b0;
    wait_idle(1000, ok);
    n_checks++; if (!ok) $display("FAIL suspend_timeout: busy=%b want 0", busy); else n_pass++;
    n_checks++; if (susp_cnt != 50) $display("FAIL suspend_cycles: got %0d want 50", susp_cnt); else n_pass++;
    n_checks++; if (susp_bad != 0) $display("FAIL suspend_outside_run: got %0d want 0", susp_bad); else n_pass++;
    n_checks++; if (run_end_q.size() != 1 || run_end_q[0] - run_start_q[0] != exp_run(0, 50))
      $display("FAIL suspend_runlen: got %0d want %0d",
               run_end_q.size() ? run_end_q[0] - run_start_q[0] : -1, exp_run(0, 50)); else n_pass++;
  endtask

  task automatic test_rst_mid();
    bit ok;
    int n = 0;
    write_entry(0, rand_entry(5, 10));
    clear_mon();
    do_start(0, 0);
    while (wq.size() < 4 && n < 100) begin tick(); n++; end
    rst = 1'b1;
    #1;
    n_checks++; if ({pg_write, pg_addr, pg_din, pg_suspend} !== 14'd0 || pg_rst !== 1'b1)
      $display("FAIL rst_mid_bus: got %b/%h/%h/%b/%b want 0/0/0/0/1", pg_write, pg_addr, pg_din, pg_suspend, pg_rst); else n_pass++;
    n_checks++; if ({busy, step_idx, step_start, seq_done} !== 7'd0)
      $display("FAIL rst_mid_status: got %b/%0d/%b/%b want 0", busy, step_idx, step_start, seq_done); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    write_entry(0, rand_entry(40, 40));
    clear_mon();
    add_step(0);
    do_start(0, 0);
    n = 0;
    while (ssq.size() < 1 && n < 100) begin tick(); n++; end
    repeat (5) tick();
    last_idx = AW'(3); loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(1000, ok);
    n_checks++; if (!ok || ssq.size() != 1)
      $display("FAIL start_in_run: got busy=%b steps=%0d want 0/1", busy, ssq.size()); else n_pass++;
    n_checks++; if (wq.size() != 8 || (wq.size() == 8 && wq != exp_wq))
      $display("FAIL start_in_run_writes: got %0d writes want 8 matching", wq.size()); else n_pass++;
    n_checks++; if (run_end_q.size() != 1 || run_end_q[0] - run_start_q[0] != exp_run(0, 0))
      $display("FAIL start_in_run_len: got %0d want %0d",
               run_end_q.size() ? run_end_q[0] - run_start_q[0] : -1, exp_run(0, 0)); else n_pass++;
    n_checks++; if (seq_done !== 1'b1) $display("FAIL start_in_run_done: got %b want 1", seq_done); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    start = 1'b0; abort = 1'b0; loop = 1'b0; last_idx = '0; ext_suspend = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_loop_abort();
    test_runlen0();
    test_suspend();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
